// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// instr_fetch_pkg : shared widths, FSM state codes and queue entry type
// Rev 1.0
// ============================================================================
package instr_fetch_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  typedef logic [1:0] fetch_state_t;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_if : instruction-memory bus and fetch-to-decode handshake
// Rev 1.0
// ============================================================================
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : small synchronous FIFO with flush, async active-low reset
// Rev 1.0
// ============================================================================
module fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       i_push,
  input  wire logic                       i_pop,
  input  wire logic                       i_flush,
  input  wire logic [DATA_W-1:0]          i_data,
  output logic      [DATA_W-1:0]          o_data,
  output logic                            o_full,
  output logic                            o_empty,
  output logic      [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : single-outstanding fetch FSM, next_pc select, queue to decode
// Rev 1.0
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int QUEUE_DEPTH = 2,
  parameter int PC_STEP     = 1
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [ADDR_W-1:0] pc,
  output logic      [ADDR_W-1:0] next_pc,
  input  wire logic              redirect_valid,
  input  wire logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_if.master          bus
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH+1);

  fetch_state_t          r_state;
  logic [ADDR_W-1:0]     r_fetch_pc;
  logic                  w_req;
  logic                  w_grant;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [INSTR_W+ADDR_W-1:0] w_head;

  // The outstanding request reserves a queue slot, so count < depth gates it.
  assign w_req   = reset && (r_state == S_IDLE) && !redirect_valid &&
                   (w_count < CNT_W'(QUEUE_DEPTH));
  assign w_grant = w_req && bus.imem_gnt;
  assign w_push  = (r_state == S_WAIT) && bus.imem_rvalid && !redirect_valid;
  assign w_pop   = !w_empty && bus.id_ready;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = !w_empty;
  assign {bus.if_instr, bus.if_pc} = w_head;

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (w_grant) begin
      next_pc = pc + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state    <= S_WAIT;
            r_fetch_pc <= pc;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_state <= bus.imem_rvalid ? S_IDLE : S_DISCARD;
          end else if (bus.imem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (bus.imem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .DATA_W (INSTR_W + ADDR_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  ({bus.imem_rdata, r_fetch_pc}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                  !(w_push && w_full));

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage sitting between the program_counter register and the decoder. Consumes the current PC, issues single-outstanding requests to instruction memory, buffers returned instructions in a small queue toward decode, and computes next_pc (hold / increment / redirect) that the program counter loads every cycle. Branch/jump redirects from execute flush the queue and discard any in-flight response.

Parameters:
ADDR_W, 16, PC and memory address width
INSTR_W, 16, instruction width
QUEUE_DEPTH, 2, instruction queue entries (power of 2, >=2)
PC_STEP, 1, PC increment per fetched instruction (word addressing)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
pc  in  ADDR_W  current PC from program_counter
next_pc  out  ADDR_W  next PC value, loaded by program_counter every clock
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  instruction memory request
imem_addr  out  ADDR_W  request address (= pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid (>=1 cycle after grant)
imem_rdata  in  INSTR_W  response instruction
if_valid  out  1  queue head valid to decode
if_instr  out  INSTR_W  queue head instruction
if_pc  out  ADDR_W  PC of queue head
id_ready  in  1  decode accepts head

Behaviour:
- Reset (reset=0, async): state IDLE, queue empty, count=0. Outputs: imem_req=0, if_valid=0, if_instr=0, if_pc=0; next_pc=pc (combinational hold).
- States: IDLE (nothing outstanding), WAIT (one request outstanding), DISCARD (outstanding request whose response must be dropped).
- imem_req=1 iff state IDLE, redirect_valid=0, and count < QUEUE_DEPTH (the outstanding slot is reserved against queue space). imem_addr=pc. Request holds, same address, until granted.
- IDLE: req&gnt -> WAIT; latch fetch PC (pc) for tagging.
- WAIT: rvalid & !redirect_valid -> push {imem_rdata, tagged PC}, -> IDLE. redirect_valid (with or without rvalid) -> rvalid ? IDLE (response dropped) : DISCARD.
- DISCARD: rvalid -> drop, -> IDLE. Redirects in DISCARD keep DISCARD.
- No new request in the same cycle a response returns (IDLE reached next cycle); min throughput 1 instr / 2 cycles with 1-cycle memory.
- next_pc priority: redirect_valid -> redirect_pc; else (imem_req & imem_gnt) -> pc + PC_STEP, modulo 2^ADDR_W (16'hFFFF -> 16'h0000); else pc.
- Queue: FIFO, push from response, pop on if_valid & id_ready. Simultaneous push+pop keeps count. Overflow impossible by reservation; push when full is an assertion failure.
- redirect_valid: queue cleared at that edge (if_valid=0 next cycle), pop in same cycle ignored; pending push dropped.
- if_valid = count != 0; if_instr/if_pc = head entry; hold stable while if_valid & !id_ready.
- Reset mid-operation: returns to IDLE immediately; a late rvalid after reset release in IDLE is ignored.

Decomposition:
- fetch_pkg: state enum (IDLE, WAIT, DISCARD), ADDR_W/INSTR_W defaults, queue entry struct {instr, pc}.
- Sub-module fetch_queue: parameterised sync FIFO (push, pop, flush, full, empty, count) with async active-low reset; instr_fetch holds FSM, next_pc logic and request gating.

Test Plan:
- Reset then pc=0, gnt=1 immediately, rvalid 1 cycle later with 16'hA001 -> next_pc=1 at grant cycle; if_valid=1, if_instr=16'hA001, if_pc=0 one cycle after rvalid.
- id_ready=0, memory returns 3 instrs -> exactly 2 queued, imem_req=0 while count=2, next_pc holds; id_ready=1 -> queue drains in order, fetch resumes.
- gnt=0 for 3 cycles -> imem_req=1, imem_addr stable, next_pc=pc throughout.
- Redirect to 16'h0040 while in WAIT, rvalid two cycles later -> queue empty next cycle, response dropped (no if_valid), next request addr 16'h0040.
- Redirect coincident with rvalid -> response dropped, state IDLE, next_pc=redirect_pc.
- pc=16'hFFFF granted -> next_pc=16'h0000; assert reset mid-WAIT -> if_valid=0, imem_req=0 while reset=0.
